// File: rtl/multi_timer_if.sv
// Register bus between a CPU-side master and the multi_timer block.
// addr is a byte address; rd is combinational read data for addr.
interface multi_timer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       wd;
  logic [31:0]       rd;

  modport master (output addr, we, wd, input  rd);
  modport slave  (input  addr, we, wd, output rd);
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NCH independent down-counting timer channels behind a small
// register bus. Per channel: CTRL (reg 0), PRESET (reg 1), COUNT (reg 2, RO).
// CTRL = {DIV[7:5], PEND[4], IM[3], MODE[2:1], EN[0]}.

// One timer channel: register file, prescaler and IDLE/LOAD/CNT/INT FSM.
module multi_timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_preset,
  input  logic [31:0]      i_wd,
  output logic [7:0]       o_ctrl,
  output logic [CNT_W-1:0] o_preset,
  output logic [CNT_W-1:0] o_count,
  output logic             o_irq
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t           r_state;
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic             r_pend;
  logic [2:0]       r_div;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic [6:0]       r_psc;

  logic [6:0]       w_mask;
  logic             w_tick;
  logic             w_unused;

  // Tick when the low DIV prescaler bits are all ones: every 2^DIV CNT cycles.
  always_comb begin
    w_mask = 7'((8'd1 << r_div) - 8'd1);
    w_tick = ((r_psc & w_mask) == w_mask);
  end

  // Channel state. Statement order encodes priorities: software EN beats the
  // one-shot EN clear, and INT setting PEND beats any PEND clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_pend   <= 1'b0;
      r_div    <= 3'd0;
      r_preset <= '0;
      r_count  <= '0;
      r_psc    <= 7'd0;
    end else begin
      case (r_state)
        S_IDLE: if (r_en) r_state <= S_LOAD;
        S_LOAD: begin
          if (i_wr_ctrl && !i_wd[0]) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_preset;
            r_psc   <= 7'd0;
            r_state <= S_CNT;
          end
        end
        S_CNT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else begin
            r_psc <= r_psc + 7'd1;
            if (w_tick) begin
              // PRESET of 0 or 1 both expire on the first tick
              if (r_count > CNT_W'(1)) begin
                r_count <= r_count - CNT_W'(1);
              end else begin
                r_count <= '0;
                r_state <= S_INT;
              end
            end
          end
        end
        S_INT: begin
          if (r_mode == 2'b01) begin
            r_state <= S_LOAD;
          end else begin
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (i_wr_ctrl) begin
        r_en   <= i_wd[0];
        r_mode <= i_wd[2:1];
        r_im   <= i_wd[3];
        r_div  <= i_wd[7:5];
        if (i_wd[4]) r_pend <= 1'b0;
      end

      // New PRESET is only picked up at the next LOAD
      if (i_wr_preset) begin
        r_preset <= i_wd[CNT_W-1:0];
        r_pend   <= 1'b0;
      end

      if (r_state == S_INT) r_pend <= 1'b1;
    end
  end

  assign o_ctrl   = {r_div, r_pend, r_im, r_mode, r_en};
  assign o_preset = r_preset;
  assign o_count  = r_count;
  assign o_irq    = r_pend & r_im;
  assign w_unused = ^i_wd;
endmodule

// Top: address decode, per-channel instances and the combinational read mux.
module multi_timer #(
  parameter int NCH    = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  multi_timer_if.slave   bus,
  output logic [NCH-1:0] irq
);
  localparam int CH_W = ADDR_W - 4;

  logic [CH_W-1:0]             w_ch;
  logic [1:0]                  w_reg;
  logic [NCH-1:0]              w_wr_ctrl;
  logic [NCH-1:0]              w_wr_preset;
  logic [NCH-1:0][7:0]         w_ctrl;
  logic [NCH-1:0][CNT_W-1:0]   w_preset;
  logic [NCH-1:0][CNT_W-1:0]   w_count;
  logic [31:0]                 w_rd;
  logic                        w_unused;

  assign w_ch     = bus.addr[ADDR_W-1:4];
  assign w_reg    = bus.addr[3:2];
  assign w_unused = ^bus.addr[1:0];

  // Channels beyond NCH never match a decode, so their writes are dropped
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_wr_ctrl[i]   = bus.we && (w_ch == CH_W'(i)) && (w_reg == 2'd0);
      assign w_wr_preset[i] = bus.we && (w_ch == CH_W'(i)) && (w_reg == 2'd1);

      multi_timer_ch #(.CNT_W(CNT_W)) u_ch (
        .clk        (clk),
        .reset      (reset),
        .i_wr_ctrl  (w_wr_ctrl[i]),
        .i_wr_preset(w_wr_preset[i]),
        .i_wd       (bus.wd),
        .o_ctrl     (w_ctrl[i]),
        .o_preset   (w_preset[i]),
        .o_count    (w_count[i]),
        .o_irq      (irq[i])
      );
    end
  endgenerate

  // Read mux from registered state only; unknown channel or reg 3 reads 0
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_ch == CH_W'(i)) begin
        case (w_reg)
          2'd0:    w_rd = 32'(w_ctrl[i]);
          2'd1:    w_rd = 32'(w_preset[i]);
          2'd2:    w_rd = 32'(w_count[i]);
          default: w_rd = '0;
        endcase
      end
    end
  end

  assign bus.rd = w_rd;
endmodule
